// File: rtl/mmu_utlb.sv
// Micro-TLB front end for one MMU port: translates unmapped segments and cached
// mappings in one cycle, and walks the main TLB on a miss with a 2-cycle latency.
module mmu_utlb #(
  parameter int UTLB_NUM  = 4,
  parameter bit DATA_PORT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vaddr,
  input  logic        req_store,
  input  logic [7:0]  req_asid,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_psyaddr,
  output logic        resp_uncached,
  output logic        resp_refill,
  output logic        resp_invalid,
  output logic        resp_modify,
  output logic        resp_store,
  output logic [18:0] s_vpn,
  output logic        s_odd,
  output logic [7:0]  s_asid,
  input  logic        s_found,
  input  logic [19:0] s_pfn,
  input  logic [2:0]  s_c,
  input  logic        s_d,
  input  logic        s_v
);
  localparam int PW = $clog2(UTLB_NUM);

  typedef enum logic {IDLE, WALK} state_e;

  state_e                state_q, state_d;
  logic [UTLB_NUM-1:0]   valid_q, valid_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [19:0]           tag_q [UTLB_NUM];
  logic [19:0]           tag_d [UTLB_NUM];
  logic [7:0]            asid_q [UTLB_NUM];
  logic [7:0]            asid_d [UTLB_NUM];
  logic [19:0]           pfn_q [UTLB_NUM];
  logic [19:0]           pfn_d [UTLB_NUM];
  logic [2:0]            c_q [UTLB_NUM];
  logic [2:0]            c_d [UTLB_NUM];
  logic [UTLB_NUM-1:0]   d_q, d_d;

  logic [31:0] hvaddr_q, hvaddr_d;
  logic [7:0]  hasid_q, hasid_d;
  logic        hstore_q, hstore_d;

  logic        rvalid_q, rvalid_d;
  logic [31:0] rpsy_q, rpsy_d;
  logic        runc_q, runc_d;
  logic        rrefill_q, rrefill_d;
  logic        rinvalid_q, rinvalid_d;
  logic        rmodify_q, rmodify_d;
  logic        rstore_q, rstore_d;

  logic        accept, is_store, hit, hit_d;
  logic [19:0] hit_pfn;
  logic [2:0]  hit_c;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign is_store  = DATA_PORT && req_store;

  assign s_vpn  = (state_q == WALK) ? hvaddr_q[31:13] : '0;
  assign s_odd  = (state_q == WALK) ? hvaddr_q[12]    : 1'b0;
  assign s_asid = (state_q == WALK) ? hasid_q         : '0;

  assign resp_valid    = rvalid_q;
  assign resp_psyaddr  = rpsy_q;
  assign resp_uncached = runc_q;
  assign resp_refill   = rrefill_q;
  assign resp_invalid  = rinvalid_q;
  assign resp_modify   = rmodify_q;
  assign resp_store    = rstore_q;

  always_comb begin
    hit     = 1'b0;
    hit_pfn = '0;
    hit_c   = '0;
    hit_d   = 1'b0;
    for (int unsigned i = 0; i < UTLB_NUM; i++) begin
      if (valid_q[i] && tag_q[i] == req_vaddr[31:12] && asid_q[i] == req_asid) begin
        hit     = 1'b1;
        hit_pfn = pfn_q[i];
        hit_c   = c_q[i];
        hit_d   = d_q[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    tag_d      = tag_q;
    asid_d     = asid_q;
    pfn_d      = pfn_q;
    c_d        = c_q;
    d_d        = d_q;
    hvaddr_d   = hvaddr_q;
    hasid_d    = hasid_q;
    hstore_d   = hstore_q;
    rvalid_d   = 1'b0;
    rpsy_d     = '0;
    runc_d     = 1'b0;
    rrefill_d  = 1'b0;
    rinvalid_d = 1'b0;
    rmodify_d  = 1'b0;
    rstore_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_vaddr[31:30] == 2'b10) begin
            rvalid_d = 1'b1;
            rpsy_d   = {3'b000, req_vaddr[28:0]};
            runc_d   = req_vaddr[29];
            rstore_d = is_store;
          end else if (hit) begin
            rvalid_d  = 1'b1;
            rpsy_d    = {hit_pfn, req_vaddr[11:0]};
            runc_d    = (hit_c == 3'b010);
            rmodify_d = is_store && !hit_d;
            rstore_d  = is_store;
          end else begin
            state_d  = WALK;
            hvaddr_d = req_vaddr;
            hasid_d  = req_asid;
            hstore_d = is_store;
          end
        end
      end
      WALK: begin
        state_d  = IDLE;
        rvalid_d = 1'b1;
        rstore_d = hstore_q;
        if (!s_found) begin
          rrefill_d = 1'b1;
        end else if (!s_v) begin
          rinvalid_d = 1'b1;
        end else begin
          rpsy_d    = {s_pfn, hvaddr_q[11:0]};
          runc_d    = (s_c == 3'b010);
          rmodify_d = hstore_q && !s_d;
          if (!flush) begin
            valid_d[ptr_q] = 1'b1;
            tag_d[ptr_q]   = hvaddr_q[31:12];
            asid_d[ptr_q]  = hasid_q;
            pfn_d[ptr_q]   = s_pfn;
            c_d[ptr_q]     = s_c;
            d_d[ptr_q]     = s_d;
            ptr_d = (ptr_q == PW'(UTLB_NUM - 1)) ? '0 : ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides any fill in the same cycle; the response above is kept.
    if (flush) begin
      valid_d = '0;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    asid_q   <= asid_d;
    pfn_q    <= pfn_d;
    c_q      <= c_d;
    d_q      <= d_d;
    hvaddr_q <= hvaddr_d;
    hasid_q  <= hasid_d;
    hstore_q <= hstore_d;
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      ptr_q      <= '0;
      rvalid_q   <= 1'b0;
      rpsy_q     <= '0;
      runc_q     <= 1'b0;
      rrefill_q  <= 1'b0;
      rinvalid_q <= 1'b0;
      rmodify_q  <= 1'b0;
      rstore_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      rvalid_q   <= rvalid_d;
      rpsy_q     <= rpsy_d;
      runc_q     <= runc_d;
      rrefill_q  <= rrefill_d;
      rinvalid_q <= rinvalid_d;
      rmodify_q  <= rmodify_d;
      rstore_q   <= rstore_d;
    end
  end
endmodule

// File: tb/tb_mmu_utlb.sv
// Directed bench for mmu_utlb: unmapped segments, miss/hit latency, exceptions,
// round-robin replacement, flush corner cases, ASID isolation and mid-walk reset.
module tb_mmu_utlb;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_store, flush;
  logic [31:0] req_vaddr;
  logic [7:0]  req_asid;
  logic        resp_valid, resp_uncached, resp_refill, resp_invalid, resp_modify, resp_store;
  logic [31:0] resp_psyaddr;
  logic [18:0] s_vpn;
  logic        s_odd;
  logic [7:0]  s_asid;
  logic        s_found, s_d, s_v;
  logic [19:0] s_pfn;
  logic [2:0]  s_c;

  int checks = 0;
  int failures = 0;

  mmu_utlb #(.UTLB_NUM(4), .DATA_PORT(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr(req_vaddr), .req_store(req_store), .req_asid(req_asid), .flush(flush),
    .resp_valid(resp_valid), .resp_psyaddr(resp_psyaddr), .resp_uncached(resp_uncached),
    .resp_refill(resp_refill), .resp_invalid(resp_invalid), .resp_modify(resp_modify),
    .resp_store(resp_store), .s_vpn(s_vpn), .s_odd(s_odd), .s_asid(s_asid),
    .s_found(s_found), .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] psy, input logic unc,
                          input logic rf, input logic inv, input logic md, input logic st);
    chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".psy"}, resp_psyaddr, psy);
    chk({tag, ".unc"}, 32'(resp_uncached), 32'(unc));
    chk({tag, ".refill"}, 32'(resp_refill), 32'(rf));
    chk({tag, ".invalid"}, 32'(resp_invalid), 32'(inv));
    chk({tag, ".modify"}, 32'(resp_modify), 32'(md));
    chk({tag, ".store"}, 32'(resp_store), 32'(st));
  endtask

  task automatic mtlb(input logic found, input logic v, input logic [19:0] pfn,
                      input logic [2:0] c, input logic d);
    s_found = found; s_v = v; s_pfn = pfn; s_c = c; s_d = d;
  endtask

  // Presents one request for one cycle; returns 1ns after the accepting edge.
  task automatic issue(input logic [31:0] va, input logic [7:0] as, input logic st,
                       input logic fl);
    @(negedge clk);
    req_valid = 1'b1; req_vaddr = va; req_asid = as; req_store = st; flush = fl;
    @(posedge clk); #1;
    req_valid = 1'b0; req_store = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_vaddr = '0; req_store = 1'b0; req_asid = '0;
    flush = 1'b0;
    mtlb(1'b0, 1'b0, 20'h0, 3'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    step();
    chk("reset.ready", 32'(req_ready), 32'd1);
    chk("reset.rvalid", 32'(resp_valid), 32'd0);
    chk("reset.psy", resp_psyaddr, 32'h0);
    chk("reset.svpn", 32'(s_vpn), 32'h0);

    // Unmapped segments
    issue(32'hBFC0_0000, 8'h05, 1'b0, 1'b0);
    chk_resp("kseg1", 32'h1FC0_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("kseg1.pulse", 32'(resp_valid), 32'd0);
    chk("kseg1.zero", resp_psyaddr, 32'h0);
    issue(32'h8000_1234, 8'h05, 1'b0, 1'b0);
    chk_resp("kseg0", 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Miss then hit
    mtlb(1'b1, 1'b1, 20'h12345, 3'd3, 1'b1);
    issue(32'h0040_1234, 8'h05, 1'b0, 1'b0);
    chk("miss.rvalid_t1", 32'(resp_valid), 32'd0);
    chk("miss.ready", 32'(req_ready), 32'd0);
    chk("miss.svpn", 32'(s_vpn), 32'h200);
    chk("miss.sodd", 32'(s_odd), 32'd1);
    chk("miss.sasid", 32'(s_asid), 32'h05);
    step();
    chk_resp("miss", 32'h1234_5234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("miss.ready_after", 32'(req_ready), 32'd1);
    mtlb(1'b0, 1'b0, 20'hFFFFF, 3'd0, 1'b0);
    issue(32'h0040_1234, 8'h05, 1'b0, 1'b0);
    chk_resp("hit", 32'h1234_5234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hit.svpn", 32'(s_vpn), 32'h0);

    // Exceptions
    issue(32'h0080_0000, 8'h05, 1'b0, 1'b0);
    chk("refill.rvalid_t1", 32'(resp_valid), 32'd0);
    step();
    chk_resp("refill", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(32'h0080_0000, 8'h05, 1'b0, 1'b0);
    chk("refill_retry.walks", 32'(req_ready), 32'd0);
    step();
    chk_resp("refill_retry", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    mtlb(1'b1, 1'b0, 20'h77777, 3'd3, 1'b1);
    issue(32'h0090_0000, 8'h05, 1'b0, 1'b0);
    step();
    chk_resp("invalid", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mtlb(1'b1, 1'b1, 20'h0ABCD, 3'd2, 1'b0);
    issue(32'h00A0_0000, 8'h05, 1'b1, 1'b0);
    step();
    chk_resp("modify_walk", 32'h0ABC_D000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mtlb(1'b0, 1'b0, 20'h0, 3'd0, 1'b0);
    issue(32'h00A0_0123, 8'h05, 1'b1, 1'b0);
    chk_resp("modify_hit", 32'h0ABC_D123, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(32'h00A0_0123, 8'h05, 1'b0, 1'b0);
    chk_resp("load_d0_hit", 32'h0ABC_D123, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Round-robin replacement: 5 fills into 4 entries evict page 0
    do_flush();
    for (int i = 0; i < 5; i++) begin
      mtlb(1'b1, 1'b1, 20'h20000 + 20'(i), 3'd3, 1'b1);
      issue(32'h0100_0000 + 32'(i) * 32'h1000, 8'h05, 1'b0, 1'b0);
      step();
      chk("rr.fill", resp_psyaddr, {20'h20000 + 20'(i), 12'h000});
    end
    mtlb(1'b0, 1'b0, 20'h0, 3'd0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      issue(32'h0100_0000 + 32'(i) * 32'h1000, 8'h05, 1'b0, 1'b0);
      chk("rr.hit_valid", 32'(resp_valid), 32'd1);
      chk("rr.hit_psy", resp_psyaddr, {20'h20000 + 20'(i), 12'h000});
    end
    issue(32'h0100_0000, 8'h05, 1'b0, 1'b0);
    chk("rr.page0_miss", 32'(resp_valid), 32'd0);
    step();
    chk("rr.page0_refill", 32'(resp_refill), 32'd1);

    // Flush during the WALK cycle: response delivered, nothing cached
    mtlb(1'b1, 1'b1, 20'h33333, 3'd3, 1'b1);
    issue(32'h0200_0000, 8'h05, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_resp("flush_walk", 32'h3333_3000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h0200_0000, 8'h05, 1'b0, 1'b0);
    chk("flush_walk.rewalk", 32'(resp_valid), 32'd0);
    step();

    // Flush coinciding with a hit uses pre-flush contents
    mtlb(1'b1, 1'b1, 20'h44444, 3'd3, 1'b1);
    issue(32'h0300_0000, 8'h05, 1'b0, 1'b0);
    step();
    issue(32'h0300_0000, 8'h05, 1'b0, 1'b1);
    chk_resp("flush_hit", 32'h4444_4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h0300_0000, 8'h05, 1'b0, 1'b0);
    chk("flush_hit.after", 32'(resp_valid), 32'd0);
    step();

    // ASID isolation
    mtlb(1'b1, 1'b1, 20'h55555, 3'd3, 1'b1);
    issue(32'h0400_0000, 8'h05, 1'b0, 1'b0);
    step();
    mtlb(1'b0, 1'b0, 20'h0, 3'd0, 1'b0);
    issue(32'h0400_0000, 8'h06, 1'b0, 1'b0);
    chk("asid.miss", 32'(resp_valid), 32'd0);
    chk("asid.sasid", 32'(s_asid), 32'h06);
    step();
    chk("asid.refill", 32'(resp_refill), 32'd1);
    issue(32'h0400_0000, 8'h05, 1'b0, 1'b0);
    chk_resp("asid.hit", 32'h5555_5000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during WALK: no response, no fill
    mtlb(1'b1, 1'b1, 20'h66666, 3'd3, 1'b1);
    issue(32'h0500_0000, 8'h05, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk("rstwalk.rvalid", 32'(resp_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    step();
    chk("rstwalk.ready", 32'(req_ready), 32'd1);
    chk("rstwalk.rvalid2", 32'(resp_valid), 32'd0);
    mtlb(1'b0, 1'b0, 20'h0, 3'd0, 1'b0);
    issue(32'h0500_0000, 8'h05, 1'b0, 1'b0);
    chk("rstwalk.nofill", 32'(resp_valid), 32'd0);
    step();
    chk("rstwalk.refill", 32'(resp_refill), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
